// File: rtl/exe_ctrl_pipe.sv
// Execute-stage control decoder with multi-cycle op sequencing and a registered output word.
// Latency: 1 cycle accept->out_valid for single-cycle ops, MC_LAT cycles for mul/div.
// Backpressure: in_ready drops while a multi-cycle op runs, while an unconsumed word is held, or on flush.
module exe_ctrl_pipe #(
  parameter int OPW    = 4,
  parameter int FNW    = 6,
  parameter int OPSELW = 5,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    opcode,
  input  logic [FNW-1:0]    funct,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPSELW-1:0] operation,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              illegal,
  output logic              mc_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MC = 2'd1, HOLD = 2'd2} state_t;

  // Counter preload: out_valid rises on the edge where the counter reads 1.
  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic [OPSELW-1:0]   r_operation;
  logic                r_mem_read, r_mem_write, r_mem_to_reg, r_illegal;

  logic [OPSELW-1:0]   w_dec_op;
  logic                w_dec_rd, w_dec_wr, w_dec_m2r, w_dec_ill, w_dec_mc;
  logic                w_accept;

  // Opcode/funct decode of the instruction currently offered upstream.
  always_comb begin
    w_dec_op  = '0;
    w_dec_rd  = 1'b0;
    w_dec_wr  = 1'b0;
    w_dec_m2r = 1'b0;
    w_dec_ill = 1'b0;
    w_dec_mc  = 1'b0;
    case (opcode)
      OPW'(4'h2): begin
        case (funct)
          FNW'(6'h20): w_dec_op = OPSELW'(5'h03);
          FNW'(6'h24): w_dec_op = OPSELW'(5'h05);
          FNW'(6'h25): w_dec_op = OPSELW'(5'h02);
          FNW'(6'h14): w_dec_op = OPSELW'(5'h04);
          FNW'(6'h08): w_dec_op = OPSELW'(5'h0B);
          FNW'(6'h27): w_dec_op = OPSELW'(5'h0A);
          FNW'(6'h2A): w_dec_op = OPSELW'(5'h08);
          FNW'(6'h2B): w_dec_op = OPSELW'(5'h09);
          FNW'(6'h00): w_dec_op = OPSELW'(5'h06);
          FNW'(6'h02): w_dec_op = OPSELW'(5'h07);
          FNW'(6'h21): begin
            w_dec_op  = OPSELW'(5'h03);
            w_dec_rd  = 1'b1;
            w_dec_m2r = 1'b1;
          end
          FNW'(6'h13): begin
            w_dec_op = OPSELW'(5'h03);
            w_dec_wr = 1'b1;
          end
          FNW'(6'h18): begin
            w_dec_op = OPSELW'(5'h0C);
            w_dec_mc = 1'b1;
          end
          FNW'(6'h1A): begin
            w_dec_op = OPSELW'(5'h0D);
            w_dec_mc = 1'b1;
          end
          default: w_dec_ill = 1'b1;
        endcase
      end
      OPW'(4'h3): w_dec_op = OPSELW'(5'h02);
      OPW'(4'h4): w_dec_op = OPSELW'(5'h03);
      OPW'(4'h5): w_dec_op = OPSELW'(5'h04);
      OPW'(4'h6): w_dec_op = OPSELW'(5'h05);
      OPW'(4'h7): w_dec_op = OPSELW'(5'h16);
      OPW'(4'hB): w_dec_op = OPSELW'(5'h01);
      default:    w_dec_ill = 1'b1;
    endcase
  end

  assign in_ready  = (r_state != MC) && (!r_out_valid || out_ready) && !flush;
  assign w_accept  = in_valid && in_ready;
  assign mc_busy   = (r_state == MC);
  assign out_valid = r_out_valid;
  assign operation = r_operation;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_to_reg = r_mem_to_reg;
  assign illegal   = r_illegal;

  // Next state, counter and out_valid; flush overrides everything else.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    if (flush) begin
      w_state_nxt     = IDLE;
      w_cnt_nxt       = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        MC: begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt     = HOLD;
            w_out_valid_nxt = 1'b1;
          end
        end
        IDLE, HOLD: begin
          if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = IDLE;
          end
          if (w_accept) begin
            if (w_dec_mc) begin
              w_state_nxt     = MC;
              w_cnt_nxt       = MC_INIT;
              w_out_valid_nxt = 1'b0;
            end else begin
              w_state_nxt     = IDLE;
              w_out_valid_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Output word captured only on accept so it stays stable while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operation  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_operation  <= w_dec_op;
      r_mem_read   <= w_dec_rd;
      r_mem_write  <= w_dec_wr;
      r_mem_to_reg <= w_dec_m2r;
      r_illegal    <= w_dec_ill;
    end
  end

endmodule

// File: tb/tb_exe_ctrl_pipe.sv
// Testbench for exe_ctrl_pipe: directed scenarios followed by random traffic.
// Expected words are queued at accept and popped by an independent output monitor.
// A cycle-count reference model predicts in_ready, out_valid and mc_busy.
module tb_exe_ctrl_pipe;
  localparam int MC_LAT = 4;

  logic       clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [3:0] opcode;
  logic [5:0] funct;
  logic [4:0] operation;
  logic       mem_read, mem_write, mem_to_reg, illegal, mc_busy;

  exe_ctrl_pipe #(.OPW(4), .FNW(6), .OPSELW(5), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .operation(operation), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .mc_busy(mc_busy)
  );

  typedef struct packed {
    logic [4:0] op;
    logic       rd, wr, m2r, ill, mc;
  } word_t;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  int    i_tab[16];
  int    r_tab[64];
  int    legal_fn[14] = '{'h20, 'h24, 'h25, 'h14, 'h08, 'h27, 'h2A, 'h2B,
                          'h00, 'h02, 'h21, 'h13, 'h18, 'h1A};

  // Reference model state: cycle numbers rather than a state machine.
  int    cyc = 0;
  int    m_mc_until = 0;
  bit    m_ov = 0, m_new = 0, m_rdy, m_acc;
  int    n_exp_pres = 0, n_pop = 0;
  bit    mon_hold = 0;
  word_t cur = '0, w_ref;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    foreach (i_tab[k]) i_tab[k] = -1;
    foreach (r_tab[k]) r_tab[k] = -1;
    i_tab[3] = 'h02; i_tab[4] = 'h03; i_tab[5] = 'h04;
    i_tab[6] = 'h05; i_tab[7] = 'h16; i_tab[11] = 'h01;
    r_tab['h20] = 'h03; r_tab['h24] = 'h05; r_tab['h25] = 'h02; r_tab['h14] = 'h04;
    r_tab['h08] = 'h0B; r_tab['h27] = 'h0A; r_tab['h2A] = 'h08; r_tab['h2B] = 'h09;
    r_tab['h00] = 'h06; r_tab['h02] = 'h07; r_tab['h21] = 'h03; r_tab['h13] = 'h03;
    r_tab['h18] = 'h0C; r_tab['h1A] = 'h0D;
  end

  function automatic word_t ref_decode(logic [3:0] op, logic [5:0] fn);
    word_t w;
    w = '0;
    if (op == 4'h2) begin
      if (r_tab[fn] >= 0) begin
        w.op  = 5'(r_tab[fn]);
        w.rd  = (fn == 6'h21);
        w.m2r = (fn == 6'h21);
        w.wr  = (fn == 6'h13);
        w.mc  = (fn == 6'h18) || (fn == 6'h1A);
      end else w.ill = 1'b1;
    end else if (i_tab[op] >= 0) w.op = 5'(i_tab[op]);
    else w.ill = 1'b1;
    return w;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: predicts handshake/status, pushes expected words on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ov = 0; m_new = 0; m_mc_until = 0;
      exp_q.delete();
      chk("rst_operation", operation, 0);
      chk("rst_membits", {mem_read, mem_write, mem_to_reg}, 0);
      chk("rst_illegal", illegal, 0);
    end
    if (m_ov && m_new) begin
      n_exp_pres++;
      m_new = 0;
    end
    m_rdy = (m_mc_until == 0) && (!m_ov || out_ready) && !flush;
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("mc_busy", mc_busy, m_mc_until != 0);
    if (rst_n) begin
      if (flush) begin
        if (m_mc_until != 0) exp_q.delete();
        m_ov = 0; m_new = 0; m_mc_until = 0;
      end else if (m_mc_until != 0) begin
        if (cyc + 1 == m_mc_until) begin
          m_ov = 1; m_new = 1; m_mc_until = 0;
        end
      end else begin
        m_acc = in_valid && m_rdy;
        if (m_ov && out_ready) m_ov = 0;
        if (m_acc) begin
          w_ref = ref_decode(opcode, funct);
          exp_q.push_back(w_ref);
          if (w_ref.mc) m_mc_until = cyc + MC_LAT;
          else begin
            m_ov = 1; m_new = 1;
          end
        end
      end
    end
    cyc++;
  end

  // Output monitor: pops one expected word per new presentation, checks stability while held.
  always @(negedge clk) begin
    if (!rst_n) mon_hold = 0;
    else if (out_valid) begin
      if (!mon_hold) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_word op=%0h queue=empty", operation);
        end else begin
          cur = exp_q.pop_front();
          n_pop++;
          chk("operation", operation, cur.op);
          chk("mem_read", mem_read, cur.rd);
          chk("mem_write", mem_write, cur.wr);
          chk("mem_to_reg", mem_to_reg, cur.m2r);
          chk("illegal", illegal, cur.ill);
        end
      end else begin
        chk("hold_word", {operation, mem_read, mem_write, mem_to_reg, illegal},
            {cur.op, cur.rd, cur.wr, cur.m2r, cur.ill});
      end
      mon_hold = !out_ready;
    end else mon_hold = 0;
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(bit iv, logic [3:0] op, logic [5:0] fn, bit ordy, bit fl);
    in_valid = iv; opcode = op; funct = fn; out_ready = ordy; flush = fl;
  endtask

  initial begin
    rst_n = 0;
    drive(0, 4'h0, 6'h0, 1, 0);
    step(3);
    rst_n = 1;
    // add
    drive(1, 4'h2, 6'h20, 1, 0); step();
    drive(0, 4'h0, 6'h0, 1, 0);  step(2);
    // lw-new then sw-new back to back
    drive(1, 4'h2, 6'h21, 1, 0); step();
    drive(1, 4'h2, 6'h13, 1, 0); step();
    drive(0, 4'h0, 6'h0, 1, 0);  step(2);
    // mul
    drive(1, 4'h2, 6'h18, 1, 0); step();
    drive(0, 4'h0, 6'h0, 1, 0);  step(6);
    // ori held for 5 cycles with a blocked follower
    drive(1, 4'h3, 6'h0, 0, 0);  step();
    drive(1, 4'h4, 6'h0, 0, 0);  step(5);
    drive(1, 4'h4, 6'h0, 1, 0);  step();
    drive(0, 4'h0, 6'h0, 1, 0);  step(2);
    // div flushed in MC cycle 2
    drive(1, 4'h2, 6'h1A, 1, 0); step();
    drive(0, 4'h0, 6'h0, 1, 0);  step();
    drive(0, 4'h0, 6'h0, 1, 1);  step();
    drive(0, 4'h0, 6'h0, 1, 0);  step(6);
    // mul abandoned by reset
    drive(1, 4'h2, 6'h18, 1, 0); step();
    drive(0, 4'h0, 6'h0, 1, 0);  step();
    rst_n = 0;                   step();
    rst_n = 1;                   step(6);
    // illegal opcode
    drive(1, 4'hF, 6'h20, 1, 0); step();
    drive(0, 4'h0, 6'h0, 1, 0);  step(2);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      logic [5:0] fn;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) op = 4'h2;
      fn = ($urandom_range(0, 4) != 0) ? 6'(legal_fn[$urandom_range(0, 13)])
                                       : 6'($urandom_range(0, 63));
      drive($urandom_range(0, 9) < 7, op, fn, $urandom_range(0, 9) < 7,
            $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        drive(0, 4'h0, 6'h0, 1, 0);
        rst_n = 0;
        step();
        rst_n = 1;
      end
      step();
    end
    drive(0, 4'h0, 6'h0, 1, 0);
    step(20);
    chk("sb_drain", exp_q.size(), 0);
    chk("words_seen", n_pop, n_exp_pres);
    chk("words_nonzero", n_pop > 50, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exe_ctrl_pipe.md
EXE_CTRL_PIPE -- requirements
Module: exe_ctrl_pipe

Interface
REQ-001 Parameter OPW, default 4, opcode width; opcode values in Function are zero-extended to OPW.
REQ-002 Parameter FNW, default 6, funct width.
REQ-003 Parameter OPSELW, default 5, ALU operation-select width.
REQ-004 Parameter MC_LAT, default 4, legal range 2..15, cycles from accept to out_valid for multi-cycle ops.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port in_valid  input  1  upstream holds a decodable instruction.
REQ-008 Port in_ready  output  1  block accepts this cycle.
REQ-009 Port opcode  input  OPW  instruction opcode.
REQ-010 Port funct  input  FNW  R-type function field.
REQ-011 Port flush  input  1  synchronous kill of all in-flight state.
REQ-012 Port out_valid  output  1  registered control word is valid.
REQ-013 Port out_ready  input  1  downstream consumes the word.
REQ-014 Port operation  output  OPSELW  ALU operation select.
REQ-015 Port mem_read, mem_write, mem_to_reg  output  1 each  memory control bits.
REQ-016 Port illegal  output  1  word came from an undefined opcode/funct.
REQ-017 Port mc_busy  output  1  multi-cycle op in progress.

Function
REQ-018 Decode, non-R opcodes SHALL be: 0x3 ori->0x02; 0x4 addi/lw/lbu/sb/sw->0x03; 0x5 andi->0x04; 0x6 beq/bne->0x05; 0x7 jal->0x16; 0xB lui->0x01; all memory bits 0.
REQ-019 Opcode 0x2 SHALL decode funct: 0x20 add->0x03; 0x24 sub->0x05; 0x25 or->0x02; 0x14 and->0x04; 0x08 jr->0x0B; 0x27 nor->0x0A; 0x2A slt->0x08; 0x2B sltu->0x09; 0x00 sll->0x06; 0x02 srl->0x07; 0x21 lw-new->0x03 with mem_read=1, mem_to_reg=1; 0x13 sw-new->0x03 with mem_write=1.
REQ-020 Opcode 0x2 funct 0x18 (mul->0x0C) and 0x1A (div->0x0D) SHALL be multi-cycle; memory bits 0.
REQ-021 Any other opcode/funct SHALL produce operation=0, memory bits 0, illegal=1, and complete as a single-cycle op.
REQ-022 FSM states SHALL be IDLE, MC, HOLD; reset state IDLE.
REQ-023 in_ready SHALL be 1 iff state!=MC and (out_valid==0 or out_ready==1) and flush==0.
REQ-024 Accept (in_valid&in_ready) of a single-cycle op SHALL register decode outputs and set out_valid=1 on the next edge (latency 1); state stays or goes IDLE.
REQ-025 Accept of a multi-cycle op SHALL load a 4-bit counter with MC_LAT-1, enter MC, set mc_busy=1, keep out_valid=0.
REQ-026 In MC the counter SHALL decrement each cycle; on the edge where it is 1 it SHALL go HOLD with out_valid=1, mc_busy=0, so out_valid rises exactly MC_LAT cycles after accept.
REQ-027 While out_valid=1 and out_ready=0, operation, memory bits and illegal SHALL hold stable.
REQ-028 out_valid&out_ready without a same-cycle accept SHALL clear out_valid on the next edge; with accept, the new word replaces it (back-to-back, no bubble).
REQ-029 flush=1 SHALL, on the next edge, clear out_valid, mc_busy and counter, return to IDLE, and block accept in that cycle regardless of in_valid.
REQ-030 Outputs other than out_valid SHALL be don't-care when out_valid=0 but SHALL not change unless a word is accepted or reset occurs.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, out_valid=0, mc_busy=0, operation=0, mem_read=mem_write=mem_to_reg=0, illegal=0, independent of clk.
REQ-032 Reset mid-MC SHALL abandon the op; no out_valid follows after release.
REQ-033 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-034 opcode 0x2 funct 0x20, out_ready=1 -> next cycle out_valid=1, operation=0x03, mem bits 0.
REQ-035 opcode 0x2 funct 0x21 streamed with 0x13 back-to-back, out_ready=1 -> two consecutive valid words: (0x03,rd=1,m2r=1) then (0x03,wr=1); in_ready never low.
REQ-036 mul accepted, MC_LAT=4 -> mc_busy high 3 cycles, in_ready=0, out_valid=1 with 0x0C on 4th cycle after accept.
REQ-037 out_ready=0 for 5 cycles after ori -> operation=0x02 held, in_ready=0; out_ready=1 -> word consumed, next accept proceeds.
REQ-038 flush during MC cycle 2, and rst_n pulse during another MC -> no out_valid, state IDLE, in_ready=1 afterwards.
REQ-039 opcode 0xF -> out_valid=1, illegal=1, operation=0.
